// File: rtl/param_universal_shift_reg.sv
// Universal shift register with eight single-step modes and a burst engine.
// A burst repeats a latched shift/rotate mode for a programmed number of edges.
module param_universal_shift_reg #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [2:0]       select,
  input  logic [WIDTH-1:0] p_din,
  input  logic             ser_in_msb,
  input  logic             ser_in_lsb,
  input  logic             start,
  input  logic [CNT_W-1:0] burst_len,
  output logic [WIDTH-1:0] p_dout,
  output logic             ser_out_lsb,
  output logic             ser_out_msb,
  output logic             busy,
  output logic             done
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] q;
  logic [2:0]       mode;
  logic [CNT_W-1:0] cnt;

  // One step of the datapath. Serial inputs and p_din are always live.
  function automatic logic [WIDTH-1:0] step(
    input logic [2:0]       m,
    input logic [WIDTH-1:0] cur,
    input logic             s_msb,
    input logic             s_lsb,
    input logic [WIDTH-1:0] pd
  );
    logic [WIDTH-1:0] nxt;
    nxt = cur;
    case (m)
      3'd0: nxt = cur;
      3'd1: nxt = {s_msb, cur[WIDTH-1:1]};
      3'd2: nxt = {cur[WIDTH-2:0], s_lsb};
      3'd3: nxt = pd;
      3'd4: nxt = {cur[0], cur[WIDTH-1:1]};
      3'd5: nxt = {cur[WIDTH-2:0], cur[WIDTH-1]};
      3'd6: nxt = {cur[WIDTH-1], cur[WIDTH-1:1]};
      3'd7: nxt = '0;
      default: nxt = cur;
    endcase
    return nxt;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      q     <= '0;
      mode  <= '0;
      cnt   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            // The start edge only latches; the first step lands on the next edge.
            mode <= select;
            cnt  <= burst_len;
            if (burst_len != '0) begin
              state <= RUN;
              busy  <= 1'b1;
            end else begin
              done <= 1'b1;
            end
          end else if (en) begin
            q <= step(select, q, ser_in_msb, ser_in_lsb, p_din);
          end
        end
        RUN: begin
          q   <= step(mode, q, ser_in_msb, ser_in_lsb, p_din);
          cnt <= cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  assign p_dout      = q;
  assign ser_out_lsb = q[0];
  assign ser_out_msb = q[WIDTH-1];

endmodule

// File: tb/tb_param_universal_shift_reg.sv
// Directed bench for param_universal_shift_reg (WIDTH=8, CNT_W=4).
// Inputs change 1 time unit after the rising edge; outputs are sampled there too.
module tb_param_universal_shift_reg;

  localparam int WIDTH = 8;
  localparam int CNT_W = 4;

  logic             clk;
  logic             rst;
  logic             en;
  logic [2:0]       select;
  logic [WIDTH-1:0] p_din;
  logic             ser_in_msb;
  logic             ser_in_lsb;
  logic             start;
  logic [CNT_W-1:0] burst_len;
  logic [WIDTH-1:0] p_dout;
  logic             ser_out_lsb;
  logic             ser_out_msb;
  logic             busy;
  logic             done;

  int errors = 0;
  int checks = 0;

  param_universal_shift_reg #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .en(en), .select(select), .p_din(p_din),
    .ser_in_msb(ser_in_msb), .ser_in_lsb(ser_in_lsb), .start(start),
    .burst_len(burst_len), .p_dout(p_dout), .ser_out_lsb(ser_out_lsb),
    .ser_out_msb(ser_out_msb), .busy(busy), .done(done)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [7:0] v);
    en = 1'b1; select = 3'd3; p_din = v;
    tick();
    en = 1'b0; select = 3'd0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      en = 1'($urandom_range(0, 1)); select = 3'($urandom_range(0, 7));
      p_din = 8'($urandom_range(0, 255)); start = 1'($urandom_range(0, 1));
      burst_len = 4'($urandom_range(0, 15));
      ser_in_msb = 1'($urandom_range(0, 1)); ser_in_lsb = 1'($urandom_range(0, 1));
      tick();
    end
    checks++;
    if (p_dout !== 8'h00 || busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL reset: p_dout=%h busy=%b done=%b, want 00 0 0", p_dout, busy, done);
    end
    rst = 1'b0; en = 1'b0; start = 1'b0; select = 3'd0; burst_len = '0;
  endtask

  task automatic test_single_step();
    logic [2:0] sel_t [7] = '{3'd3, 3'd1, 3'd2, 3'd5, 3'd4, 3'd6, 3'd7};
    logic [7:0] exp_t [7] = '{8'hB4, 8'hDA, 8'hB4, 8'h69, 8'hB4, 8'hDA, 8'h00};
    p_din = 8'hB4; ser_in_msb = 1'b1; ser_in_lsb = 1'b0;
    for (int i = 0; i < 7; i++) begin
      en = 1'b1; select = sel_t[i];
      tick();
      checks++;
      if (p_dout !== exp_t[i] || ser_out_lsb !== exp_t[i][0] || ser_out_msb !== exp_t[i][7]) begin
        errors++;
        $display("FAIL step sel=%0d: p_dout=%h lsb=%b msb=%b, want %h", sel_t[i], p_dout,
                 ser_out_lsb, ser_out_msb, exp_t[i]);
      end
    end
    load(8'h3C);
    for (int s = 0; s < 8; s++) begin
      en = 1'b0; select = 3'(s); p_din = 8'hFF;
      tick();
      checks++;
      if (p_dout !== 8'h3C) begin
        errors++;
        $display("FAIL hold en=0 sel=%0d: p_dout=%h, want 3c", s, p_dout);
      end
    end
  endtask

  task automatic test_burst_rotate();
    logic [7:0] exp_t [3] = '{8'h03, 8'h06, 8'h0C};
    load(8'h81);
    start = 1'b1; select = 3'd5; burst_len = 4'd3;
    tick();
    start = 1'b0; select = 3'd0;
    checks++;
    if (busy !== 1'b1 || done !== 1'b0 || p_dout !== 8'h81) begin
      errors++;
      $display("FAIL rot start edge: busy=%b done=%b p_dout=%h, want 1 0 81", busy, done, p_dout);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (p_dout !== exp_t[i] || busy !== (i < 2) || done !== (i == 2)) begin
        errors++;
        $display("FAIL rot step %0d: p_dout=%h busy=%b done=%b, want %h %b %b", i, p_dout,
                 busy, done, exp_t[i], i < 2, i == 2);
      end
    end
    tick();
    checks++;
    if (p_dout !== 8'h0C || busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL rot after done: p_dout=%h busy=%b done=%b, want 0c 0 0", p_dout, busy, done);
    end
  endtask

  task automatic test_burst_serial();
    logic [7:0] seq = 8'b0100_1101;
    logic [7:0] exp_q = 8'h00;
    load(8'h00);
    start = 1'b1; select = 3'd1; burst_len = 4'd8;
    tick();
    start = 1'b0;
    // Noise on ignored inputs: a live en/select must not affect the burst.
    en = 1'b1; select = 3'd3; p_din = 8'hFF; ser_in_lsb = 1'b1;
    for (int i = 0; i < 8; i++) begin
      ser_in_msb = seq[i];
      tick();
      exp_q = {seq[i], exp_q[7:1]};
      checks++;
      if (p_dout !== exp_q || ser_out_lsb !== exp_q[0] || ser_out_msb !== exp_q[7]) begin
        errors++;
        $display("FAIL serial step %0d: p_dout=%h lsb=%b msb=%b, want %h", i, p_dout,
                 ser_out_lsb, ser_out_msb, exp_q);
      end
    end
    en = 1'b0; select = 3'd0;
    checks++;
    if (p_dout !== 8'h4D || done !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL serial final: p_dout=%h done=%b busy=%b, want 4d 1 0", p_dout, done, busy);
    end
    tick();
  endtask

  task automatic test_zero_len();
    start = 1'b1; select = 3'd7; burst_len = 4'd0;
    tick();
    start = 1'b0;
    checks++;
    if (p_dout !== 8'h4D || busy !== 1'b0 || done !== 1'b1) begin
      errors++;
      $display("FAIL zero len: p_dout=%h busy=%b done=%b, want 4d 0 1", p_dout, busy, done);
    end
    tick();
    checks++;
    if (p_dout !== 8'h4D || busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL zero len after: p_dout=%h busy=%b done=%b, want 4d 0 0", p_dout, busy, done);
    end
    // A hold-mode burst still runs its full length.
    start = 1'b1; select = 3'd0; burst_len = 4'd2;
    tick();
    start = 1'b0;
    tick();
    tick();
    checks++;
    if (p_dout !== 8'h4D || busy !== 1'b0 || done !== 1'b1) begin
      errors++;
      $display("FAIL hold burst: p_dout=%h busy=%b done=%b, want 4d 0 1", p_dout, busy, done);
    end
    tick();
  endtask

  task automatic test_ignore_mid();
    int busy_n = 0;
    bit seen_done = 0;
    load(8'h01);
    start = 1'b1; select = 3'd5; burst_len = 4'd4;
    tick();
    start = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (busy === 1'b1) busy_n++;
      if (done === 1'b1) begin
        seen_done = 1;
        break;
      end
      if (i == 1) begin
        start = 1'b1; burst_len = 4'd7; en = 1'b1; select = 3'd7;
      end else if (i == 2) begin
        start = 1'b0; en = 1'b0; select = 3'd0;
      end
      tick();
    end
    checks++;
    if (busy_n != 4 || !seen_done || p_dout !== 8'h10) begin
      errors++;
      $display("FAIL mid ignore: busy cycles=%0d done=%0b p_dout=%h, want 4 1 10", busy_n,
               seen_done, p_dout);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    start = 1'b1; select = 3'd4; burst_len = 4'd2;
    tick();
    start = 1'b0;
    tick();
    tick();
    checks++;
    if (p_dout !== 8'h04 || done !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL b2b first: p_dout=%h done=%b busy=%b, want 04 1 0", p_dout, done, busy);
    end
    start = 1'b1; select = 3'd5; burst_len = 4'd2;
    tick();
    start = 1'b0;
    checks++;
    if (p_dout !== 8'h04 || busy !== 1'b1 || done !== 1'b0) begin
      errors++;
      $display("FAIL b2b restart: p_dout=%h busy=%b done=%b, want 04 1 0", p_dout, busy, done);
    end
    tick();
    tick();
    checks++;
    if (p_dout !== 8'h10 || done !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL b2b second: p_dout=%h done=%b busy=%b, want 10 1 0", p_dout, done, busy);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    int done_n = 0;
    load(8'h01);
    start = 1'b1; select = 3'd5; burst_len = 4'd10;
    tick();
    start = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    checks++;
    if (p_dout !== 8'h10 || busy !== 1'b1) begin
      errors++;
      $display("FAIL pre-reset: p_dout=%h busy=%b, want 10 1", p_dout, busy);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if (p_dout !== 8'h00 || busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL mid reset: p_dout=%h busy=%b done=%b, want 00 0 0", p_dout, busy, done);
    end
    for (int i = 0; i < 12; i++) begin
      tick();
      if (done === 1'b1 || busy === 1'b1) done_n++;
    end
    checks++;
    if (done_n != 0 || p_dout !== 8'h00) begin
      errors++;
      $display("FAIL post reset: busy/done cycles=%0d p_dout=%h, want 0 00", done_n, p_dout);
    end
    load(8'h5A);
    checks++;
    if (p_dout !== 8'h5A || busy !== 1'b0) begin
      errors++;
      $display("FAIL step after reset: p_dout=%h busy=%b, want 5a 0", p_dout, busy);
    end
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; select = 3'd0; p_din = '0; ser_in_msb = 1'b0;
    ser_in_lsb = 1'b0; start = 1'b0; burst_len = '0;
    #1;
    test_reset();
    test_single_step();
    test_burst_rotate();
    test_burst_serial();
    test_zero_len();
    test_ignore_mid();
    test_back_to_back();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
